sram_frame_port: RTL and testbench

SRAM_FRAME_PORT -- requirements
Module: sram_frame_port

---
 rtl/sram_frame_port.sv | 204 ++++++++++++++++++++
 tb/tb_sram_frame_port.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_frame_port.sv
// sram_frame_port: time-shares one asynchronous 16-bit SRAM between a video
// scan engine and a single client port. The clock runs at twice the pixel
// rate. Even (phase 0) cycles are scan slots and odd (phase 1) cycles are
// client slots.
//
// Ports
//   iCLK, iRST                  clock (2x pixel) and async active-high reset
//   iCoord_X/Y, iScan_EN        scan coordinate and visible-area flag
//   oRed/oGreen/oBlue           registered pixel colour, 4 bits/channel MSB-aligned
//   iReq/iWe/iAddr/iWdata       client request; held stable until oAck
//   oAck, oRdata                one-cycle completion pulse and read data
//   oSRAM_*                     SRAM address, shared data bus and strobes
module sram_frame_port (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [9:0]  iCoord_X,
  input  logic [9:0]  iCoord_Y,
  input  logic        iScan_EN,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  input  logic        iReq,
  input  logic        iWe,
  input  logic [19:0] iAddr,
  input  logic [15:0] iWdata,
  output logic        oAck,
  output logic [15:0] oRdata,
  output logic [19:0] oSRAM_ADDR,
  inout  wire  [15:0] ioSRAM_DQ,
  output logic        oSRAM_WE_N,
  output logic        oSRAM_OE_N,
  output logic        oSRAM_CE_N,
  output logic        oSRAM_UB_N,
  output logic        oSRAM_LB_N
);

  localparam int unsigned AW  = 20;
  localparam int unsigned DW  = 16;
  localparam int unsigned PW  = 10;
  localparam int unsigned NIB = 4;
  localparam int unsigned PAD = PW - NIB;

  typedef enum logic [1:0] {
    S_SCAN,
    S_CLI_IDLE,
    S_CLI_RD,
    S_CLI_WR
  } state_t;

  state_t          state_q, state_d;
  logic            run_q, run_d;
  logic            phase_q, phase_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_n_q, we_n_d;
  logic            oe_n_q, oe_n_d;
  logic            dq_oe_q, dq_oe_d;
  logic [DW-1:0]   dq_out_q, dq_out_d;
  logic            scan_en_q, scan_en_d;
  logic            ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [PW-1:0]   red_q, red_d;
  logic [PW-1:0]   green_q, green_d;
  logic [PW-1:0]   blue_q, blue_d;

  logic [DW-1:0]   dq_in;
  logic            leave_scan;
  logic            go_scan;

  // The data bus is only ever driven by this block during a client write slot.
  assign ioSRAM_DQ = dq_oe_q ? dq_out_q : {DW{1'bz}};
  assign dq_in     = ioSRAM_DQ;

  // run_q stays low for the first edge after reset so that edge opens a scan slot.
  assign leave_scan = run_q && !phase_q;

  // Next-state and registered-output logic.
  always_comb begin
    run_d     = 1'b1;
    phase_d   = run_q ? ~phase_q : 1'b0;
    state_d   = state_q;
    addr_d    = addr_q;
    we_n_d    = 1'b1;
    oe_n_d    = oe_n_q;
    dq_oe_d   = 1'b0;
    dq_out_d  = dq_out_q;
    scan_en_d = scan_en_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    red_d     = red_q;
    green_d   = green_q;
    blue_d    = blue_q;
    go_scan   = 1'b0;

    case (state_q)
      S_SCAN: begin
        if (leave_scan) begin
          // Pixel word read during the scan slot; blank outside the visible area.
          if (scan_en_q) begin
            red_d   = {dq_in[DW-1 -: NIB],         {PAD{1'b0}}};
            green_d = {dq_in[DW-1-NIB -: NIB],     {PAD{1'b0}}};
            blue_d  = {dq_in[DW-1-2*NIB -: NIB],   {PAD{1'b0}}};
          end else begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
          end

          // oAck still high means the client has not yet seen its completion.
          if (iReq && !ack_q) begin
            addr_d = iAddr;
            if (iWe) begin
              state_d  = S_CLI_WR;
              oe_n_d   = 1'b1;
              we_n_d   = 1'b0;
              dq_oe_d  = 1'b1;
              dq_out_d = iWdata;
            end else begin
              state_d  = S_CLI_RD;
              oe_n_d   = 1'b0;
            end
          end else begin
            state_d = S_CLI_IDLE;
            oe_n_d  = 1'b1;
          end
        end else begin
          go_scan = 1'b1;
        end
      end
      S_CLI_IDLE: begin
        go_scan = 1'b1;
      end
      S_CLI_RD: begin
        go_scan = 1'b1;
        ack_d   = 1'b1;
        rdata_d = dq_in;
      end
      S_CLI_WR: begin
        go_scan = 1'b1;
        ack_d   = 1'b1;
      end
      default: begin
        go_scan = 1'b1;
      end
    endcase

    // Open a scan slot: present the coordinate as the read address.
    if (go_scan) begin
      state_d   = S_SCAN;
      addr_d    = {iCoord_X, iCoord_Y};
      oe_n_d    = 1'b0;
      we_n_d    = 1'b1;
      dq_oe_d   = 1'b0;
      scan_en_d = iScan_EN;
    end
  end

  // State and output registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= S_SCAN;
      run_q     <= 1'b0;
      phase_q   <= 1'b0;
      addr_q    <= '0;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
      dq_out_q  <= '0;
      scan_en_q <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      phase_q   <= phase_d;
      addr_q    <= addr_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      dq_oe_q   <= dq_oe_d;
      dq_out_q  <= dq_out_d;
      scan_en_q <= scan_en_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
    end
  end

  assign oSRAM_ADDR = addr_q;
  assign oSRAM_WE_N = we_n_q;
  assign oSRAM_OE_N = oe_n_q;
  assign oSRAM_CE_N = 1'b0;
  assign oSRAM_UB_N = 1'b0;
  assign oSRAM_LB_N = 1'b0;
  assign oAck       = ack_q;
  assign oRdata     = rdata_q;
  assign oRed       = red_q;
  assign oGreen     = green_q;
  assign oBlue      = blue_q;

endmodule

// File: tb/tb_sram_frame_port.sv
// Self-checking bench for sram_frame_port with a behavioural async SRAM.
module tb_sram_frame_port;

  logic        iCLK;
  logic        iRST;
  logic [9:0]  iCoord_X, iCoord_Y;
  logic        iScan_EN;
  logic [9:0]  oRed, oGreen, oBlue;
  logic        iReq, iWe;
  logic [19:0] iAddr;
  logic [15:0] iWdata;
  logic        oAck;
  logic [15:0] oRdata;
  logic [19:0] oSRAM_ADDR;
  wire  [15:0] ioSRAM_DQ;
  logic        oSRAM_WE_N, oSRAM_OE_N, oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N;

  sram_frame_port dut (
    .iCLK(iCLK), .iRST(iRST),
    .iCoord_X(iCoord_X), .iCoord_Y(iCoord_Y), .iScan_EN(iScan_EN),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .iReq(iReq), .iWe(iWe), .iAddr(iAddr), .iWdata(iWdata),
    .oAck(oAck), .oRdata(oRdata),
    .oSRAM_ADDR(oSRAM_ADDR), .ioSRAM_DQ(ioSRAM_DQ),
    .oSRAM_WE_N(oSRAM_WE_N), .oSRAM_OE_N(oSRAM_OE_N), .oSRAM_CE_N(oSRAM_CE_N),
    .oSRAM_UB_N(oSRAM_UB_N), .oSRAM_LB_N(oSRAM_LB_N)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Behavioural asynchronous SRAM: combinational read, write while WE_N low.
  logic [15:0] mem [0:(1<<20)-1];
  assign ioSRAM_DQ = (!oSRAM_OE_N && oSRAM_WE_N) ? mem[oSRAM_ADDR] : 16'hzzzz;
  always @(posedge iCLK) if (!iRST && !oSRAM_WE_N) mem[oSRAM_ADDR] <= ioSRAM_DQ;

  // Independent slot tracker: edge 1 after reset opens phase 0.
  int unsigned edge_n;
  logic [19:0] exp_scan_addr;
  always @(posedge iCLK or posedge iRST) begin
    if (iRST) edge_n <= 0;
    else      edge_n <= edge_n + 1;
  end
  always @(posedge iCLK) if (!iRST && !edge_n[0]) exp_scan_addr <= {iCoord_X, iCoord_Y};

  function automatic bit tb_phase();
    return edge_n[0] ? 1'b0 : 1'b1;
  endfunction

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  txn_t        stim_q[$];
  txn_t        exp_q[$];
  logic [29:0] pix_q[$];
  logic [15:0] shadow [logic [19:0]];
  logic [15:0] exp_rdata;
  int          n_checks;
  int          n_fail;

  function automatic logic [15:0] shadow_rd(input logic [19:0] a);
    return shadow.exists(a) ? shadow[a] : 16'h0000;
  endfunction

  function automatic logic [29:0] pix(input logic [15:0] w, input logic en);
    return en ? {w[15:12], 6'b0, w[11:8], 6'b0, w[7:4], 6'b0} : 30'h0;
  endfunction

  task automatic push_txn(input logic we, input logic [19:0] a, input logic [15:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    if (we) begin
      t.rdata = exp_rdata;
      shadow[a] = d;
    end else begin
      t.rdata = shadow_rd(a);
      exp_rdata = t.rdata;
    end
    stim_q.push_back(t);
    exp_q.push_back(t);
  endtask

  // Continuous bus-legality and scan-slot checks.
  task automatic bus_monitor();
    forever begin
      @(negedge iCLK);
      if (!iRST && edge_n > 0) begin
        n_checks++;
        if (!oSRAM_WE_N && !oSRAM_OE_N) begin
          n_fail++; $display("FAIL bus_we_oe: WE_N=%b OE_N=%b both low at %0t", oSRAM_WE_N, oSRAM_OE_N, $time);
        end
        if (tb_phase() == 1'b0) begin
          n_checks++;
          if (oSRAM_ADDR !== exp_scan_addr || oSRAM_OE_N !== 1'b0 || oSRAM_WE_N !== 1'b1) begin
            n_fail++; $display("FAIL scan_slot: addr=%h oe=%b we=%b expected addr=%h oe=0 we=1 at %0t",
                               oSRAM_ADDR, oSRAM_OE_N, oSRAM_WE_N, exp_scan_addr, $time);
          end
          n_checks++;
          if (ioSRAM_DQ !== mem[oSRAM_ADDR]) begin
            n_fail++; $display("FAIL scan_dq: dq=%h expected %h (DUT driving?) at %0t", ioSRAM_DQ, mem[oSRAM_ADDR], $time);
          end
        end
      end
    end
  endtask

  // Drives queued client requests, holding iReq high between them, and scores each oAck.
  task automatic run_client(input int n_txn, input bit chk_spacing);
    txn_t cur, e;
    int acks = 0, cyc = 0, last_ack = -1, wr_low = 0, rd_oe = 0;
    @(posedge iCLK); #1;
    cur = stim_q.pop_front();
    iReq = 1'b1; iWe = cur.we; iAddr = cur.addr; iWdata = cur.wdata;
    while (acks < n_txn && cyc < 20 * n_txn + 20) begin
      @(negedge iCLK);
      cyc++;
      if (!oSRAM_WE_N) begin
        wr_low++;
        n_checks++;
        if (oSRAM_ADDR !== cur.addr || ioSRAM_DQ !== cur.wdata) begin
          n_fail++; $display("FAIL wr_bus: addr=%h dq=%h expected addr=%h dq=%h", oSRAM_ADDR, ioSRAM_DQ, cur.addr, cur.wdata);
        end
      end
      if (tb_phase() == 1'b1 && !oSRAM_OE_N) begin
        rd_oe++;
        n_checks++;
        if (oSRAM_ADDR !== cur.addr) begin
          n_fail++; $display("FAIL rd_addr: addr=%h expected %h", oSRAM_ADDR, cur.addr);
        end
      end
      iCoord_X = 10'($urandom_range(0, 1023));
      iCoord_Y = 10'($urandom_range(0, 1023));
      if (oAck) begin
        acks++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL spurious_ack: oAck=1 expected no pending request");
        end else begin
          e = exp_q.pop_front();
          if (oRdata !== e.rdata) begin
            n_fail++; $display("FAIL rdata: got %h expected %h (addr %h we %b)", oRdata, e.rdata, e.addr, e.we);
          end
          n_checks++;
          if (wr_low !== (e.we ? 1 : 0) || rd_oe !== (e.we ? 0 : 1)) begin
            n_fail++; $display("FAIL strobes: we_low_cycles=%0d oe_cli_cycles=%0d expected %0d/%0d",
                               wr_low, rd_oe, e.we ? 1 : 0, e.we ? 0 : 1);
          end
        end
        n_checks++;
        if (tb_phase() !== 1'b0) begin
          n_fail++; $display("FAIL ack_phase: got phase %0d expected 0", tb_phase());
        end
        if (chk_spacing && last_ack >= 0) begin
          n_checks++;
          if (cyc - last_ack != 4) begin
            n_fail++; $display("FAIL ack_spacing: got %0d cycles expected 4", cyc - last_ack);
          end
        end
        last_ack = cyc; wr_low = 0; rd_oe = 0;
        @(posedge iCLK); #1;
        n_checks++;
        if (oAck !== 1'b0) begin
          n_fail++; $display("FAIL ack_width: oAck=%b one cycle after pulse, expected 0", oAck);
        end
        if (stim_q.size() > 0) begin
          cur = stim_q.pop_front();
          iWe = cur.we; iAddr = cur.addr; iWdata = cur.wdata;
        end else begin
          iReq = 1'b0;
        end
      end
    end
    n_checks++;
    if (acks != n_txn) begin
      n_fail++; $display("FAIL ack_timeout: got %0d acks expected %0d", acks, n_txn);
    end
    iReq = 1'b0;
    stim_q.delete();
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (oSRAM_ADDR !== 20'h0 || oSRAM_WE_N !== 1'b1 || oSRAM_OE_N !== 1'b1 || oAck !== 1'b0 || oRdata !== 16'h0) begin
      n_fail++; $display("FAIL reset_bus: addr=%h we=%b oe=%b ack=%b rdata=%h expected 0/1/1/0/0",
                         oSRAM_ADDR, oSRAM_WE_N, oSRAM_OE_N, oAck, oRdata);
    end
    n_checks++;
    if ({oRed, oGreen, oBlue} !== 30'h0 || {oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pix: rgb=%h ce/ub/lb=%b expected 0/000", {oRed, oGreen, oBlue},
                         {oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N});
    end
    @(negedge iCLK);
    iCoord_X = 10'd1; iCoord_Y = 10'd2; iScan_EN = 1'b0;
    iRST = 1'b0;
    @(posedge iCLK); #1;
    n_checks++;
    if (oSRAM_OE_N !== 1'b0 || oSRAM_WE_N !== 1'b1 || oSRAM_ADDR !== {10'd1, 10'd2}) begin
      n_fail++; $display("FAIL first_slot: oe=%b we=%b addr=%h expected 0/1/%h", oSRAM_OE_N, oSRAM_WE_N, oSRAM_ADDR, {10'd1, 10'd2});
    end
    @(posedge iCLK); #1;
    n_checks++;
    if (oSRAM_OE_N !== 1'b1 || oSRAM_WE_N !== 1'b1) begin
      n_fail++; $display("FAIL idle_slot: oe=%b we=%b expected 1/1", oSRAM_OE_N, oSRAM_WE_N);
    end
  endtask

  task automatic test_write_read();
    iScan_EN = 1'b1;
    push_txn(1'b1, 20'h14064, 16'hFFFF);
    run_client(1, 1'b0);
    push_txn(1'b0, 20'h14064, 16'h0000);
    run_client(1, 1'b0);
  endtask

  task automatic test_scan();
    int xs[4] = '{5, 5, 700, 5};
    int ys[4] = '{7, 7, 500, 7};
    bit ens[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [29:0] prev;
    logic [19:0] a;
    int guard = 0;
    push_txn(1'b1, {10'd5, 10'd7}, 16'hA5C0);
    push_txn(1'b1, {10'd700, 10'd500}, 16'h3C90);
    run_client(2, 1'b0);
    do begin
      @(negedge iCLK); guard++;
    end while (tb_phase() != 1'b1 && guard < 4);
    prev = 30'h0;
    for (int i = 0; i < 4; i++) begin
      a = {10'(xs[i]), 10'(ys[i])};
      iCoord_X = 10'(xs[i]); iCoord_Y = 10'(ys[i]); iScan_EN = ens[i];
      pix_q.push_back(pix(shadow_rd(a), ens[i]));
      @(negedge iCLK);
      if (i > 0) begin
        n_checks++;
        if ({oRed, oGreen, oBlue} !== prev) begin
          n_fail++; $display("FAIL pix_hold[%0d]: rgb=%h expected %h", i, {oRed, oGreen, oBlue}, prev);
        end
      end
      @(negedge iCLK);
      prev = pix_q.pop_front();
      n_checks++;
      if ({oRed, oGreen, oBlue} !== prev) begin
        n_fail++; $display("FAIL pix[%0d]: rgb=%h expected %h", i, {oRed, oGreen, oBlue}, prev);
      end
      if (i == 0) begin
        n_checks++;
        if (oRed !== 10'h280 || oGreen !== 10'h140 || oBlue !== 10'h300) begin
          n_fail++; $display("FAIL pix_a5c0: r=%h g=%h b=%h expected 280/140/300", oRed, oGreen, oBlue);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    iScan_EN = 1'b1;
    push_txn(1'b1, 20'h2A5A5, 16'h0F0F);
    push_txn(1'b1, 20'h00001, 16'h5AA5);
    push_txn(1'b0, 20'h2A5A5, 16'h0000);
    run_client(3, 1'b1);
  endtask

  task automatic test_reset_mid_write();
    bit seen = 1'b0;
    bit ack_seen = 1'b0;
    @(posedge iCLK); #1;
    iReq = 1'b1; iWe = 1'b1; iAddr = 20'h2A5A5; iWdata = 16'h1234;
    for (int g = 0; g < 8 && !seen; g++) begin
      @(negedge iCLK);
      if (!oSRAM_WE_N) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL midwr_timeout: WE_N low seen=%b expected 1", seen);
    end
    iRST = 1'b1; iReq = 1'b0; iWe = 1'b0;
    #1;
    n_checks++;
    if (oSRAM_WE_N !== 1'b1 || oSRAM_OE_N !== 1'b1) begin
      n_fail++; $display("FAIL midwr_strobe: we=%b oe=%b expected 1/1", oSRAM_WE_N, oSRAM_OE_N);
    end
    n_checks++;
    if (ioSRAM_DQ === 16'h1234) begin
      n_fail++; $display("FAIL midwr_dq: dq=%h still driven, expected released", ioSRAM_DQ);
    end
    n_checks++;
    if (oAck !== 1'b0 || oSRAM_ADDR !== 20'h0) begin
      n_fail++; $display("FAIL midwr_regs: ack=%b addr=%h expected 0/0", oAck, oSRAM_ADDR);
    end
    @(posedge iCLK);
    @(negedge iCLK);
    iCoord_X = 10'd3; iCoord_Y = 10'd3; iScan_EN = 1'b1;
    iRST = 1'b0;
    exp_rdata = 16'h0000;
    @(posedge iCLK); #1;
    n_checks++;
    if (oSRAM_OE_N !== 1'b0 || oSRAM_WE_N !== 1'b1 || oSRAM_ADDR !== {10'd3, 10'd3}) begin
      n_fail++; $display("FAIL post_rst_slot: oe=%b we=%b addr=%h expected 0/1/%h", oSRAM_OE_N, oSRAM_WE_N, oSRAM_ADDR, {10'd3, 10'd3});
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge iCLK);
      if (oAck) ack_seen = 1'b1;
    end
    n_checks++;
    if (ack_seen) begin
      n_fail++; $display("FAIL midwr_ack: dropped write got oAck=%b expected 0", ack_seen);
    end
    push_txn(1'b0, 20'h2A5A5, 16'h0000);
    run_client(1, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; exp_rdata = 16'h0000;
    iRST = 1'b1; iReq = 1'b0; iWe = 1'b0; iAddr = '0; iWdata = '0;
    iCoord_X = '0; iCoord_Y = '0; iScan_EN = 1'b0;
    fork
      bus_monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_write_read();
    test_scan();
    test_back_to_back();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
